// File: rtl/rtlgen_pkg_v7.sv
// Shared config-fabric package: opcode, address, request and ack types used by
// every config target, plus opcode classification and byte-merge helpers.
//   cfg_opcode_t     - fabric opcodes (memory, IO, config, CR space)
//   cfg_req_64bit_t  - request beat driven by the fabric
//   cfg_ack_64bit_t  - single-cycle response returned by a target
package rtlgen_pkg_v7;

  typedef enum logic [3:0] {
    MRD   = 4'h0,
    MWR   = 4'h1,
    IORD  = 4'h2,
    IOWR  = 4'h3,
    CFGRD = 4'h4,
    CFGWR = 4'h5,
    CRRD  = 4'h6,
    CRWR  = 4'h7
  } cfg_opcode_t;

  typedef logic [47:0] cfg_addr_t;

  typedef struct packed {
    logic        valid;
    cfg_opcode_t opcode;
    cfg_addr_t   addr;
    logic [2:0]  bar;
    logic [7:0]  fid;
    logic [7:0]  be;
    logic [63:0] data;
    logic [7:0]  sai;
  } cfg_req_64bit_t;

  typedef struct packed {
    logic        read_valid;
    logic        read_miss;
    logic        write_valid;
    logic        write_miss;
    logic        sai_successfull;
    logic [63:0] data;
  } cfg_ack_64bit_t;

  // True for every opcode that reads, whether or not a given target supports it.
  function automatic logic is_read_op(input cfg_opcode_t op);
    logic res;
    case (op)
      MRD, IORD, CFGRD, CRRD: res = 1'b1;
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

  // True for every opcode that writes, whether or not a given target supports it.
  function automatic logic is_write_op(input cfg_opcode_t op);
    logic res;
    case (op)
      MWR, IOWR, CFGWR, CRWR: res = 1'b1;
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

  // Byte-enable merge: byte k of new_val replaces byte k of old_val when be[k] is set.
  function automatic logic [63:0] merge_be(input logic [63:0] old_val,
                                           input logic [63:0] new_val,
                                           input logic [7:0]  be);
    logic [63:0] res;
    res = old_val;
    for (int k = 0; k < 8; k++) begin
      res[k*8 +: 8] = be[k] ? new_val[k*8 +: 8] : old_val[k*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cfg_reg_target_decode.sv
// Combinational request decoder for cfg_reg_target.
//   req    - incoming request (only opcode/addr/bar/fid/sai are decoded)
//   hit    - supported opcode, bar/fid match, aligned and inside the register window
//   idx    - register index inside the window (meaningful only when hit)
//   is_rd  - opcode belongs to the read class
//   is_wr  - opcode belongs to the write class
//   sai_ok - requester SAI is allowed by the policy of the opcode's class
module cfg_reg_target_decode
  import rtlgen_pkg_v7::*;
#(
  parameter int          NUM_REGS  = 8,
  parameter logic [47:0] BASE_ADDR = 48'h1000,
  parameter logic [2:0]  BAR_ID    = 3'd0,
  parameter logic [7:0]  FID       = 8'd0,
  parameter logic [63:0] RD_POLICY = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic [63:0] WR_POLICY = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int          IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  cfg_req_64bit_t   req,
  output logic             hit,
  output logic [IDX_W-1:0] idx,
  output logic             is_rd,
  output logic             is_wr,
  output logic             sai_ok
);

  logic        supported_s;
  logic        short_addr_s;
  logic [47:0] offset_s;
  logic [48:0] rel_s;
  logic        in_range_s;
  logic        id_match_s;
  logic        policy_bit_s;

  // Payload fields are not needed for decoding.
  logic unused_payload_s;
  assign unused_payload_s = ^{req.valid, req.be, req.data};

  // Opcode support, address offset, window check and SAI policy lookup.
  always_comb begin
    is_rd        = is_read_op(req.opcode);
    is_wr        = is_write_op(req.opcode);
    supported_s  = 1'b0;
    short_addr_s = 1'b0;
    case (req.opcode)
      MRD, MWR: begin
        supported_s  = 1'b1;
        short_addr_s = 1'b0;
      end
      CRRD, CRWR: begin
        supported_s  = 1'b1;
        short_addr_s = 1'b1;
      end
      default: begin
        supported_s  = 1'b0;
        short_addr_s = 1'b0;
      end
    endcase

    // CR space only carries a 16-bit offset; the upper address bits are don't-care.
    if (short_addr_s) begin
      offset_s = {32'h0000_0000, req.addr[15:0]};
    end else begin
      offset_s = req.addr;
    end

    // One extra bit makes the subtraction's borrow flag "offset below BASE_ADDR".
    // BASE_ADDR is 8-byte aligned, so rel_s[2:0] equals offset[2:0].
    rel_s      = {1'b0, offset_s} - {1'b0, BASE_ADDR};
    in_range_s = !rel_s[48] && (rel_s[47:3] < 45'(NUM_REGS));
    id_match_s = (req.bar == BAR_ID) && (req.fid == FID);
    hit        = supported_s && id_match_s && (rel_s[2:0] == 3'd0) && in_range_s;
    idx        = rel_s[3 +: IDX_W];

    if (is_rd) begin
      policy_bit_s = RD_POLICY[req.sai[5:0]];
    end else if (is_wr) begin
      policy_bit_s = WR_POLICY[req.sai[5:0]];
    end else begin
      policy_bit_s = 1'b0;
    end
    sai_ok = (req.sai[7:6] == 2'b00) && policy_bit_s;
  end

endmodule

// File: rtl/cfg_reg_target.sv
// Config register target: a bank of NUM_REGS 64-bit registers reachable through
// the config request/ack fabric, with SAI read/write policy and a hardware
// update port.
//   clk, rst  - clock and asynchronous active-high reset
//   req       - fabric request, sampled whenever req.valid is high
//   ack       - registered response, one cycle after the request
//   hw_we     - per-register hardware load strobe (wins over a same-cycle cfg write)
//   hw_wdata  - hardware load data, register i at [64i+63:64i]
//   reg_q     - register contents straight from the flops
module cfg_reg_target
  import rtlgen_pkg_v7::*;
#(
  parameter int          NUM_REGS  = 8,
  parameter logic [47:0] BASE_ADDR = 48'h1000,
  parameter logic [2:0]  BAR_ID    = 3'd0,
  parameter logic [7:0]  FID       = 8'd0,
  parameter logic [63:0] RESET_VAL = 64'h0,
  parameter logic [63:0] RD_POLICY = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic [63:0] WR_POLICY = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  cfg_req_64bit_t         req,
  output cfg_ack_64bit_t         ack,
  input  logic [NUM_REGS-1:0]    hw_we,
  input  logic [NUM_REGS*64-1:0] hw_wdata,
  output logic [NUM_REGS*64-1:0] reg_q
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [NUM_REGS*64-1:0] regs_r;
  logic [NUM_REGS*64-1:0] regs_next_s;
  cfg_ack_64bit_t         ack_r;
  cfg_ack_64bit_t         ack_next_s;

  logic             hit_s;
  logic [IDX_W-1:0] idx_s;
  logic             is_rd_s;
  logic             is_wr_s;
  logic             sai_ok_s;
  logic             grant_s;
  logic             cfg_wr_s;
  logic             cfg_rd_s;
  logic [63:0]      rd_data_s;

  cfg_reg_target_decode #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR),
    .BAR_ID    (BAR_ID),
    .FID       (FID),
    .RD_POLICY (RD_POLICY),
    .WR_POLICY (WR_POLICY),
    .IDX_W     (IDX_W)
  ) u_decode (
    .req    (req),
    .hit    (hit_s),
    .idx    (idx_s),
    .is_rd  (is_rd_s),
    .is_wr  (is_wr_s),
    .sai_ok (sai_ok_s)
  );

  // Access grant, read mux, write/hardware merge and next ack.
  always_comb begin
    grant_s  = req.valid && hit_s && sai_ok_s;
    cfg_wr_s = grant_s && is_wr_s;
    cfg_rd_s = grant_s && is_rd_s;

    // Read data is the pre-update value; denied or missing reads return zero.
    if (cfg_rd_s) begin
      rd_data_s = regs_r[{idx_s, 6'b000000} +: 64];
    end else begin
      rd_data_s = 64'h0;
    end

    // Hardware load is applied last so it overrides every byte of a cfg write.
    regs_next_s = regs_r;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_next_s[i*64 +: 64] = (cfg_wr_s && (idx_s == IDX_W'(i)))
                                ? merge_be(regs_r[i*64 +: 64], req.data, req.be)
                                : regs_r[i*64 +: 64];
      regs_next_s[i*64 +: 64] = hw_we[i] ? hw_wdata[i*64 +: 64]
                                         : regs_next_s[i*64 +: 64];
    end

    ack_next_s = '0;
    if (req.valid) begin
      ack_next_s.read_valid      = is_rd_s;
      ack_next_s.read_miss       = is_rd_s && !hit_s;
      ack_next_s.write_valid     = is_wr_s;
      ack_next_s.write_miss      = is_wr_s && !hit_s;
      ack_next_s.sai_successfull = hit_s && sai_ok_s;
      ack_next_s.data            = rd_data_s;
    end else begin
      ack_next_s = '0;
    end
  end

  // Register bank and ack register; reset drops any pending ack immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_r <= {NUM_REGS{RESET_VAL}};
      ack_r  <= '0;
    end else begin
      regs_r <= regs_next_s;
      ack_r  <= ack_next_s;
    end
  end

  assign ack   = ack_r;
  assign reg_q = regs_r;

endmodule

// File: tb/tb_cfg_reg_target.sv
// Self-checking bench for cfg_reg_target: directed test-plan cases with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the register bank and ack.
module tb_cfg_reg_target;
  import rtlgen_pkg_v7::*;

  localparam int          N    = 8;
  localparam logic [47:0] BASE = 48'h1000;
  localparam logic [63:0] RDP  = ~(64'd1 << 9);
  localparam logic [63:0] WRP  = ~(64'd1 << 5);

  logic               clk = 1'b0;
  logic               rst;
  cfg_req_64bit_t     req;
  cfg_ack_64bit_t     ack;
  logic [N-1:0]       hw_we;
  logic [N*64-1:0]    hw_wdata;
  logic [N*64-1:0]    reg_q;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  logic [63:0]    mregs [N];
  logic [63:0]    pend_regs [N];
  cfg_ack_64bit_t exp_ack;
  cfg_ack_64bit_t pend_ack;

  always #5 clk = ~clk;

  cfg_reg_target #(
    .NUM_REGS  (N),
    .BASE_ADDR (BASE),
    .BAR_ID    (3'd0),
    .FID       (8'd0),
    .RESET_VAL (64'h0),
    .RD_POLICY (RDP),
    .WR_POLICY (WRP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .ack      (ack),
    .hw_we    (hw_we),
    .hw_wdata (hw_wdata),
    .reg_q    (reg_q)
  );

  // Compare process: DUT against model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (ack !== exp_ack) begin
        errors++;
        $display("FAIL ack @%0t: got rv%b rm%b wv%b wm%b ss%b d=%h, expected rv%b rm%b wv%b wm%b ss%b d=%h",
                 $time, ack.read_valid, ack.read_miss, ack.write_valid, ack.write_miss,
                 ack.sai_successfull, ack.data, exp_ack.read_valid, exp_ack.read_miss,
                 exp_ack.write_valid, exp_ack.write_miss, exp_ack.sai_successfull, exp_ack.data);
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (reg_q[i*64 +: 64] !== mregs[i]) begin
          errors++;
          $display("FAIL reg_q[%0d] @%0t: got %h expected %h", i, $time, reg_q[i*64 +: 64], mregs[i]);
        end
      end
    end
  end

  task automatic pin(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Behavioural model: what one request plus hardware strobes does to the bank.
  task automatic model_step(input cfg_req_64bit_t r, input logic [N-1:0] we,
                            input logic [N*64-1:0] wd);
    logic rd, wr, sup, hit, ok;
    logic [47:0] off;
    logic [63:0] pol;
    int idx;
    for (int i = 0; i < N; i++) pend_regs[i] = mregs[i];
    pend_ack = '0;
    if (r.valid) begin
      rd  = r.opcode inside {MRD, IORD, CFGRD, CRRD};
      wr  = r.opcode inside {MWR, IOWR, CFGWR, CRWR};
      sup = r.opcode inside {MRD, MWR, CRRD, CRWR};
      off = (r.opcode inside {CRRD, CRWR}) ? (r.addr % 48'h10000) : r.addr;
      hit = sup && (r.bar == 3'd0) && (r.fid == 8'd0) && (off % 8 == 0) &&
            (off >= BASE) && (off < BASE + 48'(8 * N));
      idx = hit ? int'((off - BASE) / 8) : 0;
      pol = rd ? RDP : WRP;
      ok  = (r.sai < 8'd64) && pol[r.sai[5:0]];
      pend_ack.read_valid      = rd;
      pend_ack.write_valid     = wr;
      pend_ack.read_miss       = rd && !hit;
      pend_ack.write_miss      = wr && !hit;
      pend_ack.sai_successfull = hit && ok;
      pend_ack.data            = (rd && hit && ok) ? mregs[idx] : 64'h0;
      if (wr && hit && ok) begin
        for (int k = 0; k < 8; k++) begin
          if (r.be[k]) pend_regs[idx][k*8 +: 8] = r.data[k*8 +: 8];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (we[i]) pend_regs[i] = wd[i*64 +: 64];
    end
  endtask

  // One clock: drive inputs at posedge+1, advance model when they are sampled.
  task automatic cycle(input cfg_req_64bit_t r, input logic [N-1:0] we,
                       input logic [N*64-1:0] wd);
    req      = r;
    hw_we    = we;
    hw_wdata = wd;
    model_step(r, we, wd);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) mregs[i] = pend_regs[i];
    exp_ack = pend_ack;
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    req      = '0;
    hw_we    = '0;
    hw_wdata = '0;
    for (int i = 0; i < N; i++) mregs[i] = 64'h0;
    exp_ack = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  function automatic cfg_req_64bit_t mk(input cfg_opcode_t op, input logic [47:0] a,
                                        input logic [7:0] be, input logic [63:0] d,
                                        input logic [7:0] sai, input logic [2:0] bar);
    cfg_req_64bit_t r;
    r        = '0;
    r.valid  = 1'b1;
    r.opcode = op;
    r.addr   = a;
    r.be     = be;
    r.data   = d;
    r.sai    = sai;
    r.bar    = bar;
    r.fid    = 8'd0;
    return r;
  endfunction

  function automatic cfg_req_64bit_t rand_req();
    cfg_req_64bit_t r;
    int k;
    int sel;
    r        = '0;
    r.valid  = ($urandom_range(0, 9) != 0);
    r.opcode = cfg_opcode_t'(4'($urandom_range(0, 7)));
    k        = $urandom_range(0, N - 1);
    sel      = $urandom_range(0, 9);
    case (sel)
      6:       r.addr = BASE + 48'(8 * k) + 48'($urandom_range(1, 7));
      7:       r.addr = BASE + 48'(8 * N) + 48'(8 * k);
      8:       r.addr = BASE - 48'd8;
      9:       r.addr = {32'($urandom), 16'(16'h1000 + 16'(8 * k))};
      default: r.addr = BASE + 48'(8 * k);
    endcase
    r.bar  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    r.fid  = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
    case ($urandom_range(0, 5))
      0:       r.sai = 8'd5;
      1:       r.sai = 8'd9;
      2:       r.sai = 8'($urandom);
      default: r.sai = 8'($urandom_range(0, 63));
    endcase
    r.be   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
    r.data = {32'($urandom), 32'($urandom)};
    return r;
  endfunction

  logic [N*64-1:0] wd_v;
  logic [N-1:0]    we_v;

  initial begin
    rst      = 1'b1;
    req      = '0;
    hw_we    = '0;
    hw_wdata = '0;
    for (int i = 0; i < N; i++) mregs[i] = 64'h0;
    exp_ack = '0;
    chk_en  = 1'b1;
    do_reset(2);

    // Reset value read.
    cycle(mk(MRD, 48'h1008, 8'hFF, 64'h0, 8'd0, 3'd0), '0, '0);
    pin("rst_rd_valid", 64'(ack.read_valid), 64'd1);
    pin("rst_rd_miss", 64'(ack.read_miss), 64'd0);
    pin("rst_rd_sai", 64'(ack.sai_successfull), 64'd1);
    pin("rst_rd_data", ack.data, 64'h0);

    // Byte-enabled write, then read-back the next cycle.
    cycle(mk(MWR, 48'h1010, 8'h0F, 64'h1122334455667788, 8'd0, 3'd0), '0, '0);
    pin("bew_wv", 64'(ack.write_valid), 64'd1);
    pin("bew_sai", 64'(ack.sai_successfull), 64'd1);
    pin("bew_reg2", reg_q[2*64 +: 64], 64'h0000000055667788);
    cycle(mk(MRD, 48'h1010, 8'hFF, 64'h0, 8'd0, 3'd0), '0, '0);
    pin("bew_rd", ack.data, 64'h0000000055667788);

    // Misses.
    cycle(mk(MRD, 48'h1040, 8'hFF, 64'h0, 8'd0, 3'd0), '0, '0);
    pin("miss_oor", 64'(ack.read_miss), 64'd1);
    pin("miss_oor_d", ack.data, 64'h0);
    cycle(mk(MWR, 48'h1004, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'd0, 3'd0), '0, '0);
    pin("miss_align", 64'(ack.write_miss), 64'd1);
    pin("miss_align_r0", reg_q[63:0], 64'h0);
    cycle(mk(CFGRD, 48'h1000, 8'hFF, 64'h0, 8'd0, 3'd0), '0, '0);
    pin("miss_cfg", 64'(ack.read_miss), 64'd1);
    cycle(mk(MRD, 48'h1010, 8'hFF, 64'h0, 8'd0, 3'd1), '0, '0);
    pin("miss_bar", 64'(ack.read_miss), 64'd1);

    // SAI policy.
    cycle(mk(MWR, 48'h1000, 8'hFF, 64'hDEAD_BEEF, 8'd5, 3'd0), '0, '0);
    pin("sai_wv", 64'(ack.write_valid), 64'd1);
    pin("sai_wm", 64'(ack.write_miss), 64'd0);
    pin("sai_ss", 64'(ack.sai_successfull), 64'd0);
    pin("sai_r0", reg_q[63:0], 64'h0);
    cycle(mk(MRD, 48'h1010, 8'hFF, 64'h0, 8'h45, 3'd0), '0, '0);
    pin("sai45_ss", 64'(ack.sai_successfull), 64'd0);
    pin("sai45_d", ack.data, 64'h0);

    // Hardware update collides with a cfg write to the same register.
    wd_v = '0;
    wd_v[1*64 +: 64] = 64'hAAAA;
    cycle(mk(MWR, 48'h1008, 8'hFF, 64'h5555, 8'd0, 3'd0), 8'b0000_0010, wd_v);
    pin("hw_win", reg_q[1*64 +: 64], 64'hAAAA);

    // be=0 hit write changes nothing but still succeeds.
    cycle(mk(MWR, 48'h1008, 8'h00, 64'h1234, 8'd0, 3'd0), '0, '0);
    pin("be0_ss", 64'(ack.sai_successfull), 64'd1);
    pin("be0_reg1", reg_q[1*64 +: 64], 64'hAAAA);

    // CR space ignores the upper address bits.
    cycle(mk(CRWR, 48'hABCD_0000_1018, 8'hFF, 64'hC0FFEE, 8'd0, 3'd0), '0, '0);
    pin("cr_reg3", reg_q[3*64 +: 64], 64'hC0FFEE);

    // Reset mid-operation drops the pending ack and clears the bank.
    cycle(mk(MWR, 48'h1020, 8'hFF, 64'h77, 8'd0, 3'd0), '0, '0);
    cycle(mk(MRD, 48'h1020, 8'hFF, 64'h0, 8'd0, 3'd0), '0, '0);
    rst = 1'b1;
    #1;
    pin("mid_rst_ack", ack.data, 64'h0);
    pin("mid_rst_rv", 64'(ack.read_valid), 64'd0);
    pin("mid_rst_reg3", reg_q[3*64 +: 64], 64'h0);
    do_reset(1);
    cycle(mk(MRD, 48'h1020, 8'hFF, 64'h0, 8'd0, 3'd0), '0, '0);
    pin("post_rst_rv", 64'(ack.read_valid), 64'd1);
    pin("post_rst_d", ack.data, 64'h0);
    cycle(mk(MWR, 48'h1020, 8'hFF, 64'h99, 8'd0, 3'd0), '0, '0);
    cycle(mk(MRD, 48'h1020, 8'hFF, 64'h0, 8'd0, 3'd0), '0, '0);
    pin("post_rst_wr", ack.data, 64'h99);

    // Randomized traffic, with one reset pulse in the middle.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset(2);
      we_v = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      for (int i = 0; i < N; i++) wd_v[i*64 +: 64] = {32'($urandom), 32'($urandom)};
      cycle(rand_req(), we_v, wd_v);
    end

    cycle('0, '0, '0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
